dm_latency_bridge: RTL and testbench
====================================

// Module: dm_latency_bridge
// PURPOSE
//  Sits between Core's DM interface and the DM dram. Turns each core data access
//  into a multi-cycle memory transaction with programmable latency, and drives
//  Core.DM_stall (replacing the constant 1'b0 tie-off).
//  Handles byte/half/word widths via wwide, flags misaligned accesses and keeps
//  request/stall statistics that the bench prints next to total cycles.
// PARAMETERS
//  LATENCY     2    memory cycles per access, legal range 1..15
//  ADDR_WIDTH  32   core address width; the mem side uses the same width
//  CNT_WIDTH   32   width of the statistics counters
// PORTS
//  CLK          in   1   clock, rising edge
//  RST          in   1   synchronous, active-high reset
//  core_req     in   1   core presents a DM access this cycle
//  core_wen     in   1   1 = write, 0 = read; sampled with core_req
//  core_wwide   in   3   1 = byte, 2 = half, 4 = word; any other value is treated as word
//  core_addr    in   32  byte address
//  core_wdata   in   32  write data, right-justified
//  core_rdata   out  32  read data, zero-extended and right-justified; valid in RESP
//  core_stall   out  1   to Core DM_stall
//  mem_addr     out  32  address to dram, aligned to the access size
//  mem_wdata    out  32  write data to dram, right-justified
//  mem_wen      out  1   dram write strobe
//  mem_wwide    out  3   dram write width
//  mem_rdata    in   32  dram read data, valid the cycle after mem_addr is stable
//  misalign     out  1   sticky misaligned-access flag
//  req_count    out  CNT accepted requests
//  stall_count  out  CNT cycles with core_stall = 1
// BEHAVIOUR
//  Reset: state IDLE, cnt = 0. Outputs: core_stall 0, mem_wen 0, core_rdata 0,
//   mem_addr 0, misalign 0, both counters 0. RST mid-transaction aborts it:
//   no write is issued and no data is returned.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: core_stall = core_req (combinational). When core_req = 1:
//    - latch addr, wdata, wen, wwide
//    - cnt <= LATENCY - 1
//    - go to WAIT
//    - req_count += 1
//   WAIT: core_stall = 1; mem_addr/mem_wdata/mem_wwide are driven from the latches.
//    - cnt decrements each cycle.
//    - Write: mem_wen = 1 for exactly one cycle, the cycle where cnt == 0.
//    - Read: mem_rdata is captured into the read latch at cnt == 0.
//    - At cnt == 0, go to RESP.
//   RESP: core_stall = 0; core_rdata is driven from the read latch.
//    - core_req is ignored here; the core's next access appears after the edge.
//    - Always go to IDLE.
//  Timing per access: core_stall high for LATENCY + 1 cycles, then 1 RESP cycle.
//   Back-to-back accesses leave one IDLE gap.
//  Alignment:
//   - half with addr[0] = 1, or word with addr[1:0] != 0, sets misalign (sticky until RST).
//   - The access is still performed at the address aligned down.
//  Read lanes are little-endian:
//   - byte = mem_rdata >> 8*addr[1:0], masked to 8 bits
//   - half = mem_rdata >> 16*addr[1], masked to 16 bits
//  stall_count += 1 on every cycle with core_stall = 1.
//   Both counters saturate at all-ones and never wrap.
//  core_req = 1 together with RST: RST wins, the request is not counted.
// STRUCTURE
//  Shared package/define file: localparams WW_BYTE = 3'd1, WW_HALF = 3'd2,
//   WW_WORD = 3'd4; state encodings S_IDLE / S_WAIT / S_RESP.
//  One sub-module: dm_lane_align (combinational) computes aligned addr, extracted
//   read lanes and the misalign bit from {addr[1:0], wwide, rdata}.
//  The FSM, latency counter and statistics counters live in the top module.
// TESTING
//  1. LATENCY = 2, word read at addr 0x10 with mem word 0xDEADBEEF
//     -> core_stall high 3 cycles, then RESP with core_rdata = 0xDEADBEEF;
//        req_count = 1, stall_count = 3.
//  2. Word write 0x12345678 to 0x20 -> mem_wen high exactly one cycle (last WAIT),
//     mem_addr = 0x20; golden mem[0x20..0x23] = 78 56 34 12.
//  3. Byte read at 0x13 with mem word 0xAABBCCDD -> core_rdata = 0x000000AA.
//     Half read at 0x12 -> core_rdata = 0x0000AABB.
//  4. Word read at 0x22 -> misalign = 1, mem_addr = 0x20.
//     Flag stays set through 3 later aligned accesses until RST.
//  5. RST asserted in the first WAIT cycle of a write -> no mem_wen pulse,
//     next cycle state IDLE, core_stall 0, counters 0.
//  6. Two consecutive reads with LATENCY = 1 -> each stalls 2 cycles, one IDLE gap
//     between them; req_count = 2, stall_count = 4.

Source files
------------

// File: rtl/dm_latency_bridge_pkg.sv
// Shared constants for the DM latency bridge: access widths, FSM encodings and
// the width-normalisation helper used by the bridge and its lane aligner.
package dm_latency_bridge_pkg;

   localparam logic [2:0] WW_BYTE = 3'd1;
   localparam logic [2:0] WW_HALF = 3'd2;
   localparam logic [2:0] WW_WORD = 3'd4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Any width code other than byte/half is handled as a full word.
   function automatic logic [2:0] ww_norm(input logic [2:0] ww);
      logic [2:0] res;
      case (ww)
         WW_BYTE: res = WW_BYTE;
         WW_HALF: res = WW_HALF;
         default: res = WW_WORD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dm_latency_bridge_if.sv
// Core-side and dram-side signals of the DM latency bridge; the bridge uses the
// slave view, the surrounding core/dram environment uses the master view.
interface dm_latency_bridge_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  core_req;
   logic                  core_wen;
   logic [2:0]            core_wwide;
   logic [ADDR_WIDTH-1:0] core_addr;
   logic [31:0]           core_wdata;
   logic [31:0]           core_rdata;
   logic                  core_stall;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_wen;
   logic [2:0]            mem_wwide;
   logic [31:0]           mem_rdata;

   modport slave (
      input  core_req, core_wen, core_wwide, core_addr, core_wdata, mem_rdata,
      output core_rdata, core_stall, mem_addr, mem_wdata, mem_wen, mem_wwide
   );

   modport master (
      output core_req, core_wen, core_wwide, core_addr, core_wdata, mem_rdata,
      input  core_rdata, core_stall, mem_addr, mem_wdata, mem_wen, mem_wwide
   );
endinterface

// File: rtl/dm_latency_bridge_lane_align.sv
// Combinational lane logic: aligns the low address bits to the access size,
// extracts little-endian read lanes and flags misaligned half/word accesses.
module dm_lane_align
   import dm_latency_bridge_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_wwide,
   input  logic [31:0] i_rdata,
   output logic [1:0]  o_addr_lo,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);
   logic [31:0] w_byte_shift;
   logic [31:0] w_half_shift;

   assign w_byte_shift = i_rdata >> {i_addr_lo, 3'b000};
   assign w_half_shift = i_rdata >> {i_addr_lo[1], 4'b0000};

   // Per-width alignment, lane select and misalign detection.
   always_comb begin
      o_addr_lo  = 2'b00;
      o_rdata    = i_rdata;
      o_misalign = 1'b0;
      case (ww_norm(i_wwide))
         WW_BYTE: begin
            o_addr_lo  = i_addr_lo;
            o_rdata    = {24'd0, w_byte_shift[7:0]};
            o_misalign = 1'b0;
         end
         WW_HALF: begin
            o_addr_lo  = {i_addr_lo[1], 1'b0};
            o_rdata    = {16'd0, w_half_shift[15:0]};
            o_misalign = i_addr_lo[0];
         end
         default: begin
            o_addr_lo  = 2'b00;
            o_rdata    = i_rdata;
            o_misalign = |i_addr_lo;
         end
      endcase
   end
endmodule

// File: rtl/dm_latency_bridge.sv
// DM latency bridge: stretches each core data access into a LATENCY-cycle dram
// transaction, drives the core stall and keeps saturating request/stall counts.
module dm_latency_bridge
   import dm_latency_bridge_pkg::*;
#(
   parameter int LATENCY    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   dm_latency_bridge_if.slave   bus,
   output logic                 misalign,
   output logic [CNT_WIDTH-1:0] req_count,
   output logic [CNT_WIDTH-1:0] stall_count
);
   localparam logic [3:0]           CNT_INIT = 4'(LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic                  r_wen;
   logic [2:0]            r_wwide;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rdata;
   logic                  r_misalign;
   logic [CNT_WIDTH-1:0]  r_req_count;
   logic [CNT_WIDTH-1:0]  r_stall_count;

   logic                  w_stall;
   logic                  w_accept;
   logic                  w_last;
   logic [1:0]            w_addr_lo;
   logic [31:0]           w_lane_rdata;
   logic                  w_misalign;

   dm_lane_align u_lane_align (
      .i_addr_lo  (r_addr[1:0]),
      .i_wwide    (r_wwide),
      .i_rdata    (bus.mem_rdata),
      .o_addr_lo  (w_addr_lo),
      .o_rdata    (w_lane_rdata),
      .o_misalign (w_misalign)
   );

   // Stall: the IDLE cycle of a new request plus every WAIT cycle.
   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         S_IDLE:  w_stall = bus.core_req;
         S_WAIT:  w_stall = 1'b1;
         S_RESP:  w_stall = 1'b0;
         default: w_stall = 1'b0;
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && bus.core_req;
   assign w_last   = (r_state == S_WAIT) && (r_cnt == 4'd0);

   // Transaction FSM and latency down-counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.core_req) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CNT_INIT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request latches, captured once per accepted access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wen   <= 1'b0;
         r_wwide <= WW_WORD;
         r_addr  <= '0;
         r_wdata <= 32'd0;
      end else if (w_accept) begin
         r_wen   <= bus.core_wen;
         r_wwide <= ww_norm(bus.core_wwide);
         r_addr  <= bus.core_addr;
         r_wdata <= bus.core_wdata;
      end
   end

   // Read latch and sticky misalign flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rdata    <= 32'd0;
         r_misalign <= 1'b0;
      end else begin
         if (w_last && !r_wen) begin
            r_rdata <= w_lane_rdata;
         end
         if ((r_state == S_WAIT) && w_misalign) begin
            r_misalign <= 1'b1;
         end
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_req_count   <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_accept && (r_req_count != CNT_MAX)) begin
            r_req_count <= r_req_count + CNT_ONE;
         end
         if (w_stall && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
      end
   end

   assign bus.core_stall = w_stall;
   assign bus.core_rdata = r_rdata;
   assign bus.mem_addr   = {r_addr[ADDR_WIDTH-1:2], w_addr_lo};
   assign bus.mem_wdata  = r_wdata;
   assign bus.mem_wwide  = r_wwide;
   assign bus.mem_wen    = w_last && r_wen;

   assign misalign    = r_misalign;
   assign req_count   = r_req_count;
   assign stall_count = r_stall_count;
endmodule

// File: tb/tb_dm_latency_bridge.sv
// Directed bench for dm_latency_bridge: table of accesses on a LATENCY=2 bridge
// with a byte-array dram model, plus reset-abort and LATENCY=1 saturation sequences.
module tb_dm_latency_bridge;
   logic CLK;
   logic RST;

   int checks   = 0;
   int failures = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   dm_latency_bridge_if #(.ADDR_WIDTH(32)) a_if ();
   dm_latency_bridge_if #(.ADDR_WIDTH(32)) b_if ();

   logic        a_misalign, b_misalign;
   logic [31:0] a_req_count, a_stall_count;
   logic [2:0]  b_req_count, b_stall_count;

   dm_latency_bridge #(.LATENCY(2), .ADDR_WIDTH(32), .CNT_WIDTH(32)) dut_a (
      .CLK(CLK), .RST(RST), .bus(a_if.slave), .misalign(a_misalign),
      .req_count(a_req_count), .stall_count(a_stall_count)
   );

   dm_latency_bridge #(.LATENCY(1), .ADDR_WIDTH(32), .CNT_WIDTH(3)) dut_b (
      .CLK(CLK), .RST(RST), .bus(b_if.slave), .misalign(b_misalign),
      .req_count(b_req_count), .stall_count(b_stall_count)
   );

   // Byte-array dram for dut_a: word-granular reads, right-justified writes.
   logic [7:0]  mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;
   int          a_wen_total = 0;
   logic [7:0]  a_widx;

   assign a_widx = {a_if.mem_addr[7:2], 2'b00};
   always_comb a_if.mem_rdata = {mem[a_widx + 8'd3], mem[a_widx + 8'd2],
                                 mem[a_widx + 8'd1], mem[a_widx]};
   always_comb b_if.mem_rdata = 32'h0BAD_F00D ^ b_if.mem_addr;

   always @(posedge CLK) begin
      if (pl_en) begin
         mem[pl_addr]        <= pl_data[7:0];
         mem[pl_addr + 8'd1] <= pl_data[15:8];
         mem[pl_addr + 8'd2] <= pl_data[23:16];
         mem[pl_addr + 8'd3] <= pl_data[31:24];
      end else if (a_if.mem_wen) begin
         a_wen_total <= a_wen_total + 1;
         mem[a_if.mem_addr[7:0]] <= a_if.mem_wdata[7:0];
         if (a_if.mem_wwide != 3'd1) begin
            mem[a_if.mem_addr[7:0] + 8'd1] <= a_if.mem_wdata[15:8];
         end
         if ((a_if.mem_wwide != 3'd1) && (a_if.mem_wwide != 3'd2)) begin
            mem[a_if.mem_addr[7:0] + 8'd2] <= a_if.mem_wdata[23:16];
            mem[a_if.mem_addr[7:0] + 8'd3] <= a_if.mem_wdata[31:24];
         end
      end
   end

   typedef struct {
      logic        pre;
      logic [31:0] pre_word;
      logic        wen;
      logic [2:0]  ww;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_maddr;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] addr, input logic [31:0] data);
      @(negedge CLK);
      pl_addr = addr;
      pl_data = data;
      pl_en   = 1'b1;
      @(negedge CLK);
      pl_en   = 1'b0;
   endtask

   task automatic run_a(input vec_t v, output int stalls, output int wens, output int wen_pos,
                        output logic [31:0] rd, output logic [31:0] maddr, output bit got);
      if (v.pre) preload({v.exp_maddr[7:2], 2'b00}, v.pre_word);
      @(negedge CLK);
      a_if.core_req   = 1'b1;
      a_if.core_wen   = v.wen;
      a_if.core_wwide = v.ww;
      a_if.core_addr  = v.addr;
      a_if.core_wdata = v.wdata;
      stalls = 0; wens = 0; wen_pos = -1; rd = 32'd0; maddr = 32'd0; got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (a_if.core_stall) begin
            if (a_if.mem_wen) begin
               wens++;
               wen_pos = stalls;
            end
            stalls++;
         end else begin
            got   = 1'b1;
            rd    = a_if.core_rdata;
            maddr = a_if.mem_addr;
            break;
         end
         @(negedge CLK);
      end
      a_if.core_req = 1'b0;
   endtask

   initial begin
      int          stalls, wens, wen_pos, wen_before;
      logic [31:0] rd, maddr, cur_addr;
      bit          got;

      //          pre   pre_word       wen   ww    addr          wdata          exp_rdata      exp_maddr     mis
      vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 3'd4, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'h0000_0010, 1'b0};
      vecs[1] = '{1'b0, 32'h0,        1'b1, 3'd4, 32'h0000_0020, 32'h12345678, 32'h0,        32'h0000_0020, 1'b0};
      vecs[2] = '{1'b1, 32'hAABBCCDD, 1'b0, 3'd1, 32'h0000_0013, 32'h0,        32'h000000AA, 32'h0000_0013, 1'b0};
      vecs[3] = '{1'b0, 32'h0,        1'b0, 3'd2, 32'h0000_0012, 32'h0,        32'h0000AABB, 32'h0000_0012, 1'b0};
      vecs[4] = '{1'b0, 32'h0,        1'b0, 3'd4, 32'h0000_0022, 32'h0,        32'h12345678, 32'h0000_0020, 1'b1};
      vecs[5] = '{1'b0, 32'h0,        1'b0, 3'd1, 32'h0000_0021, 32'h0,        32'h00000056, 32'h0000_0021, 1'b1};
      vecs[6] = '{1'b1, 32'h11223344, 1'b1, 3'd2, 32'h0000_0030, 32'h0000BEEF, 32'h0,        32'h0000_0030, 1'b1};
      vecs[7] = '{1'b0, 32'h0,        1'b0, 3'd7, 32'h0000_0030, 32'h0,        32'h1122BEEF, 32'h0000_0030, 1'b1};
      vecs[8] = '{1'b0, 32'h0,        1'b0, 3'd2, 32'h0000_0032, 32'h0,        32'h00001122, 32'h0000_0032, 1'b1};

      pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
      a_if.core_wen = 1'b0; a_if.core_wwide = 3'd4; a_if.core_addr = 32'd0; a_if.core_wdata = 32'd0;
      b_if.core_wen = 1'b0; b_if.core_wwide = 3'd4; b_if.core_addr = 32'd0; b_if.core_wdata = 32'd0;
      // Requests held during reset must not be counted.
      a_if.core_req = 1'b1;
      b_if.core_req = 1'b1;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      a_if.core_req = 1'b0;
      b_if.core_req = 1'b0;
      #1;
      chk("rst_stall", {31'd0, a_if.core_stall}, 32'd0);
      chk("rst_mem_wen", {31'd0, a_if.mem_wen}, 32'd0);
      chk("rst_rdata", a_if.core_rdata, 32'd0);
      chk("rst_mem_addr", a_if.mem_addr, 32'd0);
      chk("rst_misalign", {31'd0, a_misalign}, 32'd0);
      chk("rst_req_count", a_req_count, 32'd0);
      chk("rst_stall_count", a_stall_count, 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_a(vecs[i], stalls, wens, wen_pos, rd, maddr, got);
         if (!got) begin
            checks++;
            failures++;
            $display("FAIL vec%0d_timeout: no RESP cycle within 20 cycles", i);
         end
         chk($sformatf("vec%0d_stall_cycles", i), 32'(stalls), 32'd3);
         chk($sformatf("vec%0d_wen_pulses", i), 32'(wens), vecs[i].wen ? 32'd1 : 32'd0);
         if (vecs[i].wen) chk($sformatf("vec%0d_wen_pos", i), 32'(wen_pos), 32'd2);
         else             chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_mem_addr", i), maddr, vecs[i].exp_maddr);
         chk($sformatf("vec%0d_misalign", i), {31'd0, a_misalign}, {31'd0, vecs[i].exp_mis});
         chk($sformatf("vec%0d_req_count", i), a_req_count, 32'(i + 1));
         chk($sformatf("vec%0d_stall_count", i), a_stall_count, 32'(3 * (i + 1)));
      end

      @(negedge CLK);
      chk("mem20_word", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h12345678);
      chk("mem30_word", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h1122BEEF);

      // Reset during the first WAIT cycle of a write aborts it.
      preload(8'h40, 32'h0000_0000);
      wen_before = a_wen_total;
      @(negedge CLK);
      a_if.core_req = 1'b1; a_if.core_wen = 1'b1; a_if.core_wwide = 3'd4;
      a_if.core_addr = 32'h40; a_if.core_wdata = 32'hFFFF_FFFF;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("abort_wen_in_wait", {31'd0, a_if.mem_wen}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      a_if.core_req = 1'b0;
      a_if.core_wen = 1'b0;
      #1;
      chk("abort_stall", {31'd0, a_if.core_stall}, 32'd0);
      chk("abort_req_count", a_req_count, 32'd0);
      chk("abort_stall_count", a_stall_count, 32'd0);
      chk("abort_misalign", {31'd0, a_misalign}, 32'd0);
      chk("abort_rdata", a_if.core_rdata, 32'd0);
      repeat (3) @(negedge CLK);
      chk("abort_no_wen", 32'(a_wen_total - wen_before), 32'd0);
      chk("abort_mem40", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'd0);

      // LATENCY=1, requests held back-to-back; 3-bit counters saturate.
      @(negedge CLK);
      b_if.core_req = 1'b1;
      b_if.core_addr = 32'h0;
      for (int k = 0; k < 4; k++) begin
         stalls = 0;
         got = 1'b0;
         cur_addr = b_if.core_addr;
         for (int c = 0; c < 10; c++) begin
            #1;
            if (b_if.core_stall) begin
               stalls++;
            end else begin
               got = 1'b1;
               rd  = b_if.core_rdata;
               break;
            end
            @(negedge CLK);
         end
         if (!got) begin
            checks++;
            failures++;
            $display("FAIL b%0d_timeout: no RESP cycle within 10 cycles", k);
         end
         chk($sformatf("b%0d_stall_cycles", k), 32'(stalls), 32'd2);
         chk($sformatf("b%0d_rdata", k), rd, 32'h0BAD_F00D ^ cur_addr);
         if (k == 1) begin
            chk("b_two_req_count", {29'd0, b_req_count}, 32'd2);
            chk("b_two_stall_count", {29'd0, b_stall_count}, 32'd4);
         end
         b_if.core_addr = 32'(4 * (k + 1));
         if (k == 3) b_if.core_req = 1'b0;
         @(negedge CLK);
      end
      #1;
      chk("b_gap_idle_stall", {31'd0, b_if.core_stall}, 32'd0);
      chk("b_req_count_4", {29'd0, b_req_count}, 32'd4);
      chk("b_stall_count_sat", {29'd0, b_stall_count}, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
